rtc_write_sequencer: RTL and testbench
======================================

// Module: rtc_write_sequencer
// PURPOSE
//  Write-side counterpart of the RTC read address sequencer. On request it walks
//  the RTC register map (time/date 0x21-0x26, timer 0x41-0x43), presents each
//  address plus the host-supplied byte, and pulses a write strobe for each one.
//  It ends with a commit write. Sits between the user set-time/set-timer logic
//  and the shared RTC bus driver.
// PARAMETERS
//  HOLD_CYCLES  12'h04A  cycles each address/data slot is held (min 4)
//  COMMIT_ADDR  8'hF1    address of the final commit/transfer write
//  COMMIT_DATA  8'h00    data byte of the commit write
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  reset      in   1  asynchronous, active-low reset
//  start      in   1  write-request pulse; sampled only in IDLE
//  sel        in   2  group select: 01 time/date, 10 timer, 11 both, 00 none
//  abort      in   1  synchronous cancel of an active sequence
//  data_in    in   8  byte for the current entry, valid while data_idx is stable
//  data_idx   out  4  entry index requested from host (0-5 time/date, 6-8 timer)
//  address    out  8  RTC register address, 8'h00 when idle
//  data_out   out  8  byte to write, 8'h00 when idle
//  data_oe    out  1  bus driver enable for address/data (replaces hi-Z)
//  wr_stb     out  1  write strobe to RTC bus driver
//  busy       out  1  high from leaving IDLE through DONE
//  done       out  1  one-cycle pulse when the commit slot completes
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, slot counter=1, data_idx=0, address=0,
//   data_out=0, data_oe=0, wr_stb=0, busy=0, done=0. All outputs are registered.
//  State machine:
//   IDLE: on start && sel!=00, latch sel and go to LOAD. Set busy=1 and data_idx
//    to the first entry of the group (0 or 6). start with sel==00 is ignored.
//   LOAD: one cycle. data_in is captured into data_out. address comes from the
//    table (idx0-5 -> 21..26, idx6-8 -> 41..43). data_oe=1. Go to SLOT.
//    Counter=1.
//   SLOT: counter counts 1..HOLD_CYCLES. wr_stb=1 while 2<=counter<=HOLD_CYCLES-1.
//    address/data_out stay stable for the whole slot. At counter==HOLD_CYCLES:
//    if the entry is the last of the latched group, go to COMMIT. Otherwise
//    data_idx++ and go to LOAD. sel=11 runs 0..8 without a gap.
//   COMMIT: same slot timing, with address=COMMIT_ADDR and data_out=COMMIT_DATA.
//    At the end go to DONE.
//   DONE: one cycle. done=1, data_oe=0, address/data_out=0, then IDLE, busy=0.
//  Latency: start in cycle 0 -> first address valid in cycle 2 -> first wr_stb in
//   cycle 3. Total busy = 1 + N*(HOLD_CYCLES+1) + (HOLD_CYCLES+1) + 1 cycles,
//   where N is 6, 3 or 9.
//  Data capture: data_in is sampled only in LOAD. Later changes within the slot
//   are ignored.
//  start while busy: ignored, not queued. sel changes while busy: ignored.
//  abort: in any non-IDLE state, the next cycle forces wr_stb=0, data_oe=0 and
//   address=0, and the FSM goes to IDLE. done is not pulsed. abort has priority
//   over slot completion in the same cycle.
//  Async reset mid-slot: outputs drop immediately, with no partial-strobe
//   guarantee. The RTC write then counts as not performed.
//  Counter is 12 bits and wraps only through reload to 1, never by overflow.
// STRUCTURE
//  Shared package: register address constants (ADDR_SEC..ADDR_YEAR = 21..26,
//   ADDR_TMR0..2 = 41..43), group index bounds and the FSM state encoding. The
//   read sequencer uses the same map.
//  One natural sub-module: rtc_slot_timer (counter 1..HOLD_CYCLES, strobe window,
//   slot_end pulse). It is shared with the read sequencer for timing parity.
//  The address table is a combinational case on data_idx inside the top module.
// TESTING (bench uses HOLD_CYCLES=4)
//  1. sel=01 with start pulse, data_in=8'h30+idx -> six slots at 21..26 carrying
//     30..35, then F1/00, then done. Exactly 7 wr_stb pulses, each 2 cycles wide.
//  2. sel=10 -> addresses 41,42,43 then F1. busy spans 1+3*5+5+1 = 22 cycles.
//  3. sel=11 -> 21..26 then 41..43 back-to-back, then one commit. data_idx goes
//     0..8 in order.
//  4. abort in slot 3 of sel=01 (at counter=2) -> next cycle wr_stb=0, data_oe=0,
//     address=00, busy=0, and done is never asserted.
//  5. reset asserted mid-SLOT -> outputs 0 in the same cycle. A start after
//     release restarts from idx0.
//  6. start with sel=00, and start while busy -> no state change and no extra
//     slots.

Source files
------------

// File: rtl/rtc_write_sequencer_pkg.sv
// Shared RTC register map, entry index bounds and sequencer state encoding.
// The read-side sequencer imports the same definitions.
package rtc_write_sequencer_pkg;

  // Time/date block
  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;

  // Timer block
  localparam logic [7:0] ADDR_TMR0  = 8'h41;
  localparam logic [7:0] ADDR_TMR1  = 8'h42;
  localparam logic [7:0] ADDR_TMR2  = 8'h43;

  // Host entry indices: time/date occupies 0-5, timer 6-8
  localparam logic [3:0] TD_FIRST   = 4'd0;
  localparam logic [3:0] TD_LAST    = 4'd5;
  localparam logic [3:0] TMR_FIRST  = 4'd6;
  localparam logic [3:0] TMR_LAST   = 4'd8;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_TD   = 2'b01,
    SEL_TMR  = 2'b10,
    SEL_BOTH = 2'b11
  } grp_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SLOT,
    ST_COMMIT,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/rtc_write_sequencer_slot_timer.sv
// Slot timer: counts 1..HOLD_CYCLES while run is high, registered strobe window
// 2..HOLD_CYCLES-1, slot_end on the last count. Dropping run reloads the count.
module rtc_slot_timer #(
  parameter logic [11:0] HOLD_CYCLES = 12'h04A
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic strobe,
  output logic slot_end
);

  logic [11:0] count;
  logic [11:0] count_nxt;

  // Reload instead of overflow keeps the count inside 1..HOLD_CYCLES
  assign count_nxt = (count == HOLD_CYCLES) ? 12'd1 : count + 12'd1;
  assign slot_end  = run && (count == HOLD_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 12'd1;
      strobe <= 1'b0;
    end else if (!run) begin
      count  <= 12'd1;
      strobe <= 1'b0;
    end else begin
      count  <= count_nxt;
      strobe <= (count_nxt >= 12'd2) && (count_nxt <= HOLD_CYCLES - 12'd1);
    end
  end

endmodule

// File: rtl/rtc_write_sequencer.sv
// Walks the selected RTC register groups, presenting address/data and a write
// strobe for each entry, then issues the commit write and pulses done.
module rtc_write_sequencer
  import rtc_write_sequencer_pkg::*;
#(
  parameter logic [11:0] HOLD_CYCLES = 12'h04A,
  parameter logic [7:0]  COMMIT_ADDR = 8'hF1,
  parameter logic [7:0]  COMMIT_DATA = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic       abort,
  input  logic [7:0] data_in,
  output logic [3:0] data_idx,
  output logic [7:0] address,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       wr_stb,
  output logic       busy,
  output logic       done
);

  seq_state_t state;
  grp_sel_t   grp;
  logic       cmt_arm;
  logic       run;
  logic       slot_end;
  logic [7:0] tbl_addr;
  logic [3:0] last_idx;

  always_comb begin
    tbl_addr = 8'h00;
    case (data_idx)
      4'd0:    tbl_addr = ADDR_SEC;
      4'd1:    tbl_addr = ADDR_MIN;
      4'd2:    tbl_addr = ADDR_HOUR;
      4'd3:    tbl_addr = ADDR_DAY;
      4'd4:    tbl_addr = ADDR_MONTH;
      4'd5:    tbl_addr = ADDR_YEAR;
      4'd6:    tbl_addr = ADDR_TMR0;
      4'd7:    tbl_addr = ADDR_TMR1;
      4'd8:    tbl_addr = ADDR_TMR2;
      default: tbl_addr = 8'h00;
    endcase
  end

  assign last_idx = (grp == SEL_TD) ? TD_LAST : TMR_LAST;

  // The first COMMIT cycle loads the commit byte, mirroring LOAD, so the commit
  // slot has the same length as a register slot.
  assign run = !abort && ((state == ST_SLOT) || (state == ST_COMMIT && !cmt_arm));

  rtc_slot_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_slot_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .strobe   (wr_stb),
    .slot_end (slot_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      grp      <= SEL_NONE;
      cmt_arm  <= 1'b0;
      data_idx <= 4'd0;
      address  <= 8'h00;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state    <= ST_IDLE;
        cmt_arm  <= 1'b0;
        data_idx <= 4'd0;
        address  <= 8'h00;
        data_out <= 8'h00;
        data_oe  <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // busy still high here means this is the cycle carrying done
            if (busy) begin
              busy <= 1'b0;
            end else if (start && sel != SEL_NONE) begin
              grp      <= grp_sel_t'(sel);
              data_idx <= sel[0] ? TD_FIRST : TMR_FIRST;
              busy     <= 1'b1;
              state    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            data_out <= data_in;
            address  <= tbl_addr;
            data_oe  <= 1'b1;
            state    <= ST_SLOT;
          end
          ST_SLOT: begin
            if (slot_end) begin
              if (data_idx == last_idx) begin
                cmt_arm <= 1'b1;
                state   <= ST_COMMIT;
              end else begin
                data_idx <= data_idx + 4'd1;
                state    <= ST_LOAD;
              end
            end
          end
          ST_COMMIT: begin
            if (cmt_arm) begin
              cmt_arm  <= 1'b0;
              address  <= COMMIT_ADDR;
              data_out <= COMMIT_DATA;
            end else if (slot_end) begin
              address  <= 8'h00;
              data_out <= 8'h00;
              data_oe  <= 1'b0;
              state    <= ST_DONE;
            end
          end
          ST_DONE: begin
            done     <= 1'b1;
            data_idx <= 4'd0;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Directed bench: stimulus queues expected writes, a negedge monitor pops and
// compares on every wr_stb rising edge and tracks strobe width, done and busy.
module tb_rtc_write_sequencer;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] idx;
    logic       chk_idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [7:0] data_in;
  logic [3:0] data_idx;
  logic [7:0] address, data_out;
  logic       data_oe, wr_stb, busy, done;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, errs = 0;
  int   stb_cnt = 0, done_cnt = 0, busy_len = 0, busy_run = 0, stb_w = 0;
  bit   cut = 1'b0;
  logic stb_prev = 1'b0, busy_prev = 1'b0;

  rtc_write_sequencer #(
    .HOLD_CYCLES (12'd4),
    .COMMIT_ADDR (8'hF1),
    .COMMIT_DATA (8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sel      (sel),
    .abort    (abort),
    .data_in  (data_in),
    .data_idx (data_idx),
    .address  (address),
    .data_out (data_out),
    .data_oe  (data_oe),
    .wr_stb   (wr_stb),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Host byte is 30+idx, scrambled during the strobe window to prove late changes are ignored
  assign data_in = (8'h30 + {4'h0, data_idx}) ^ (wr_stb ? 8'hFF : 8'h00);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] exp_addr(input int i);
    logic [7:0] a;
    if (i < 6) a = 8'h21 + 8'(i);
    else       a = 8'h41 + 8'(i - 6);
    return a;
  endfunction

  task automatic push_group(input int first, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = exp_addr(first + i);
      e.data = 8'h30 + 8'(first + i);
      e.idx = 4'(first + i);
      e.chk_idx = 1'b1;
      exp_q.push_back(e);
    end
    e.addr = 8'hF1; e.data = 8'h00; e.idx = 4'd0; e.chk_idx = 1'b0;
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard pop on strobe rise, width, done and busy bookkeeping
  always @(negedge clk) begin
    if (wr_stb && !stb_prev) begin
      stb_cnt++;
      if (exp_q.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_stb: got addr %0h data %0h want no strobe", address, data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("stb_addr", address, mon_e.addr);
        check("stb_data", data_out, mon_e.data);
        check("stb_oe", data_oe, 1);
        if (mon_e.chk_idx) check("stb_idx", data_idx, mon_e.idx);
      end
    end
    if (wr_stb) stb_w++;
    else begin
      if (stb_prev && !cut && reset) check("stb_width", stb_w, 2);
      stb_w = 0;
    end
    if (done) done_cnt++;
    if (busy) busy_run++;
    else begin
      if (busy_prev) busy_len = busy_run;
      busy_run = 0;
    end
    stb_prev = wr_stb;
    busy_prev = busy;
  end

  // Full sequence; caller is just past a posedge. poke>0 fires a stray start/sel change mid-run.
  task automatic run(input logic [1:0] s, input int n, input int busy_exp, input int poke);
    int cnt, lat_a, lat_s, s0, d0;
    push_group((s == 2'b10) ? 6 : 0, n);
    s0 = stb_cnt; d0 = done_cnt;
    sel = s; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0; lat_a = 0; lat_s = 0;
    while (!done && cnt < 2000) begin
      @(negedge clk); cnt++;
      if (lat_a == 0 && address != 8'h00) lat_a = cnt;
      if (lat_s == 0 && wr_stb) lat_s = cnt;
      if (poke != 0 && cnt == poke) begin start = 1'b1; sel = 2'b01; end
      else if (poke != 0 && cnt == poke + 1) start = 1'b0;
    end
    check("run_timeout", (cnt < 2000), 1);
    repeat (2) @(negedge clk);
    check("lat_addr", lat_a, 2);
    check("lat_stb", lat_s, 3);
    check("stb_count", stb_cnt - s0, n + 1);
    check("done_count", done_cnt - d0, 1);
    check("busy_len", busy_len, busy_exp);
    check("queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt, s0, d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", address, 8'h00);
    check("rst_data", data_out, 8'h00);
    check("rst_idx", data_idx, 4'd0);
    check("rst_oe", data_oe, 0);
    check("rst_stb", wr_stb, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run(2'b01, 6, 37, 0);
    run(2'b10, 3, 22, 0);
    run(2'b11, 9, 52, 0);

    // start with sel=00 is ignored
    s0 = stb_cnt;
    sel = 2'b00; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("sel00_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("sel00_stb", stb_cnt - s0, 0);
    @(posedge clk); #1;

    // start and sel change while busy are ignored
    run(2'b10, 3, 22, 8);

    // abort at counter=2 of the third time/date slot
    push_group(0, 6);
    d0 = done_cnt;
    sel = 2'b01; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    while (!(wr_stb && address == 8'h23) && cnt < 500) begin @(negedge clk); cnt++; end
    check("abort_wait", (cnt < 500), 1);
    cut = 1'b1; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_stb", wr_stb, 0);
    check("abort_oe", data_oe, 0);
    check("abort_addr", address, 8'h00);
    check("abort_busy", busy, 0);
    repeat (30) @(negedge clk);
    check("abort_nodone", done_cnt - d0, 0);
    check("abort_left", exp_q.size(), 4);
    exp_q.delete();
    cut = 1'b0;
    @(posedge clk); #1;

    // async reset mid-slot drops outputs immediately
    push_group(0, 6);
    sel = 2'b01; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    while (!(wr_stb && address == 8'h22) && cnt < 500) begin @(negedge clk); cnt++; end
    check("rst_wait", (cnt < 500), 1);
    #2 cut = 1'b1; reset = 1'b0;
    #1;
    check("midrst_stb", wr_stb, 0);
    check("midrst_oe", data_oe, 0);
    check("midrst_addr", address, 8'h00);
    check("midrst_data", data_out, 8'h00);
    check("midrst_busy", busy, 0);
    check("midrst_idx", data_idx, 4'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    cut = 1'b0;
    @(posedge clk); #1;
    run(2'b01, 6, 37, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want bench completion");
    $fatal(1, "watchdog");
  end

endmodule
